// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the core (master 0) and a
// loader/DMA engine (master 1). One transaction at a time, round-robin on ties.
module mem_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_ready,
  output logic        m0_done,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_ready,
  output logic        m1_done,
  output logic [31:0] m1_rdata,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  state_t      state;
  logic        last;
  logic        owner;
  logic        we_l;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic [3:0]  wmask_l;
  logic [2:0]  cnt;

  logic        grant_valid;
  logic        winner;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    grant_valid = (state == IDLE) && (m0_req || m1_req);
    if (m0_req && m1_req) begin
      winner = ~last;
    end else begin
      winner = m1_req;
    end
  end

  assign m0_ready = grant_valid && !winner && m0_req;
  assign m1_ready = grant_valid &&  winner && m1_req;

  // Transaction FSM: latch the command, issue it, count out read latency, report completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      we_l     <= 1'b0;
      addr_l   <= 32'h0;
      wdata_l  <= 32'h0;
      wmask_l  <= 4'h0;
      cnt      <= 3'd0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= 32'h0;
      m1_rdata <= 32'h0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= winner;
            last    <= winner;
            we_l    <= winner ? m1_we    : m0_we;
            addr_l  <= winner ? m1_addr  : m0_addr;
            wdata_l <= winner ? m1_wdata : m0_wdata;
            wmask_l <= winner ? m1_wmask : m0_wmask;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_l) begin
            state   <= IDLE;
            m0_done <= !owner;
            m1_done <= owner;
          end else begin
            state <= WAIT;
            cnt   <= 3'd1;
          end
        end
        WAIT: begin
          if (cnt == LAT) begin
            state <= IDLE;
            cnt   <= 3'd0;
            if (owner) begin
              m1_rdata <= mem_rdata;
              m1_done  <= 1'b1;
            end else begin
              m0_rdata <= mem_rdata;
              m0_done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign mem_addr  = addr_l;
  assign mem_wdata = wdata_l;
  assign mem_we    = (state == ISSUE) && we_l;
  assign mem_wmask = mem_we ? wmask_l : 4'b0000;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives both masters from command queues, models the memory
// latency, and checks grants, bus activity and completions against a scoreboard.
module tb_mem_arbiter;

  localparam int RL = 3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          delay;
  } cmd_t;

  typedef struct {
    int          owner;
    int          cyc;
    bit          isRead;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wmask [2];
  logic [1:0]  ready;
  logic [1:0]  done;
  logic [31:0] rdata [2];
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_arbiter #(.READ_LAT(RL)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (req[0]),
    .m0_we     (we[0]),
    .m0_addr   (addr[0]),
    .m0_wdata  (wdata[0]),
    .m0_wmask  (wmask[0]),
    .m0_ready  (ready[0]),
    .m0_done   (done[0]),
    .m0_rdata  (rdata[0]),
    .m1_req    (req[1]),
    .m1_we     (we[1]),
    .m1_addr   (addr[1]),
    .m1_wdata  (wdata[1]),
    .m1_wmask  (wmask[1]),
    .m1_ready  (ready[1]),
    .m1_done   (done[1]),
    .m1_rdata  (rdata[1]),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  int nChecks = 0;
  int nFails  = 0;

  cmd_t q0[$];
  cmd_t q1[$];
  exp_t sb[$];
  int   grants[$];
  int   grantCyc[$];

  int          cyc = 0;
  bit          txnValid = 0;
  int          issueCyc = 0;
  int          busyEnd = 0;
  bit          tWe = 0;
  logic [3:0]  tMask = 4'h0;
  logic [31:0] expAddr = 32'h0;
  logic [31:0] expWdata = 32'h0;
  logic [31:0] expRdata [2] = '{32'h0, 32'h0};
  bit          mlast = 1'b1;
  int          rdValidCyc = -1;
  logic [31:0] rdValidData = 32'h0;
  bit          accepted [2] = '{1'b0, 1'b0};
  int          lastAcc [2] = '{-100, -100};

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h20) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, actual, expected);
    end
  endtask

  task automatic pushCmd(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] mk, input int dly);
    cmd_t c;
    c.we = w; c.addr = a; c.wdata = d; c.wmask = mk; c.delay = dly;
    if (m == 0) q0.push_back(c);
    else q1.push_back(c);
  endtask

  // Raise the next queued command for master m, or scramble its idle command lines
  task automatic applyStimulus(input int m, input bit rst);
    cmd_t c;
    bit   have;
    have = 1'b0;
    if (req[m]) return;
    if (m == 0 && q0.size() > 0) begin c = q0[0]; have = 1'b1; end
    if (m == 1 && q1.size() > 0) begin c = q1[0]; have = 1'b1; end
    if (have && !rst && cyc >= lastAcc[m] + 1 + c.delay) begin
      if (m == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      we[m] = c.we; addr[m] = c.addr; wdata[m] = c.wdata; wmask[m] = c.wmask;
      req[m] = 1'b1;
    end else begin
      we[m] = 1'($urandom); addr[m] = $urandom; wdata[m] = $urandom; wmask[m] = 4'($urandom);
    end
  endtask

  // Compare every observable output against the model, then advance the model
  task automatic monitor();
    bit   busyExp;
    bit   weExp;
    int   w;
    exp_t e;
    busyExp = txnValid && (cyc <= busyEnd);
    weExp   = txnValid && (cyc == issueCyc) && tWe;
    checkOutput("busy", 32'(busy), 32'(busyExp));
    checkOutput("mem_we", 32'(mem_we), 32'(weExp));
    checkOutput("mem_wmask", 32'(mem_wmask), weExp ? 32'(tMask) : 32'h0);
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_wdata", mem_wdata, expWdata);
    for (int m = 0; m < 2; m++) begin
      if (done[m]) begin
        if (sb.size() == 0) begin
          checkOutput(m == 0 ? "m0_done_spurious" : "m1_done_spurious", 32'(done[m]), 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_owner", 32'(m), 32'(e.owner));
          checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
          if (e.isRead) expRdata[e.owner] = e.data;
        end
      end
      checkOutput(m == 0 ? "m0_rdata" : "m1_rdata", rdata[m], expRdata[m]);
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checkOutput("done_missing", 32'h0, 32'h1);
      if (e.isRead) expRdata[e.owner] = e.data;
    end

    w = -1;
    if (!busyExp && (req[0] || req[1])) begin
      if (req[0] && req[1]) w = mlast ? 0 : 1;
      else w = req[0] ? 0 : 1;
    end
    checkOutput("m0_ready", 32'(ready[0]), 32'(w == 0));
    checkOutput("m1_ready", 32'(ready[1]), 32'(w == 1));
    checkOutput("ready_both", 32'(ready[0] & ready[1]), 32'h0);

    if (reset) begin
      txnValid = 1'b0;
      expAddr = 32'h0;
      expWdata = 32'h0;
      expRdata[0] = 32'h0;
      expRdata[1] = 32'h0;
      mlast = 1'b1;
      sb.delete();
      rdValidCyc = -1;
    end else if (w >= 0) begin
      accepted[w] = 1'b1;
      lastAcc[w] = cyc;
      txnValid = 1'b1;
      issueCyc = cyc + 1;
      tWe = we[w];
      tMask = wmask[w];
      busyEnd = we[w] ? cyc + 1 : cyc + 1 + RL;
      expAddr = addr[w];
      expWdata = wdata[w];
      mlast = w[0];
      e.owner = w;
      e.cyc = we[w] ? cyc + 2 : cyc + 2 + RL;
      e.isRead = !we[w];
      e.data = memData(addr[w]);
      sb.push_back(e);
      if (!we[w]) begin
        rdValidCyc = cyc + 1 + RL;
        rdValidData = memData(addr[w]);
      end
      grants.push_back(w);
      grantCyc.push_back(cyc);
    end
  endtask

  // One clock: drive inputs just after the rising edge, check on the falling edge
  task automatic step(input bit rst);
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
    for (int m = 0; m < 2; m++) begin
      if (accepted[m]) begin
        req[m] = 1'b0;
        accepted[m] = 1'b0;
      end
    end
    applyStimulus(0, rst);
    applyStimulus(1, rst);
    mem_rdata = (cyc == rdValidCyc) ? rdValidData : $urandom;
    @(negedge clk);
    monitor();
  endtask

  task automatic runUntilQuiet(input int limit);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req != 2'b00 || sb.size() > 0) && n < limit) begin
      step(1'b0);
      n++;
    end
    if (n >= limit) checkOutput("timeout", 32'(n), 32'(limit - 1));
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req = 2'b00;
    we = 2'b00;
    for (int m = 0; m < 2; m++) begin
      addr[m] = 32'h0; wdata[m] = 32'h0; wmask[m] = 4'h0;
    end
    mem_rdata = 32'h0;

    step(1'b1);
    step(1'b1);
    step(1'b0);

    // Single write from master 0
    pushCmd(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    runUntilQuiet(50);

    // Single read from master 1
    pushCmd(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    runUntilQuiet(50);
    checkOutput("m1_read_value", rdata[1], 32'h12345678);

    // Byte store on one lane
    pushCmd(0, 1'b1, 32'h32, 32'h00AB0000, 4'b0100, 0);
    runUntilQuiet(50);

    // Back-to-back from master 0, each re-raised in the done cycle of the previous one
    grants.delete();
    grantCyc.delete();
    pushCmd(0, 1'b1, 32'h40, 32'h11111111, 4'hF, 0);
    pushCmd(0, 1'b1, 32'h44, 32'h22222222, 4'h3, 1);
    pushCmd(0, 1'b0, 32'h48, 32'h0, 4'h0, 1);
    pushCmd(0, 1'b1, 32'h4C, 32'h33333333, 4'hC, RL + 1);
    runUntilQuiet(100);
    checkOutput("b2b_count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      checkOutput("b2b_gap0", 32'(grantCyc[1] - grantCyc[0]), 32'd2);
      checkOutput("b2b_gap1", 32'(grantCyc[2] - grantCyc[1]), 32'd2);
      checkOutput("b2b_gap2", 32'(grantCyc[3] - grantCyc[2]), 32'(RL + 2));
    end

    // Contention from reset: both masters request reads continuously
    step(1'b1);
    step(1'b1);
    grants.delete();
    grantCyc.delete();
    for (int i = 0; i < 4; i++) begin
      pushCmd(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, 0);
      pushCmd(1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'h0, 0);
    end
    runUntilQuiet(200);
    checkOutput("contend_count", 32'(grants.size()), 32'd8);
    if (grants.size() > 0) checkOutput("contend_first", 32'(grants[0]), 32'd0);
    for (int i = 1; i < grants.size(); i++) begin
      checkOutput("contend_alternate", 32'(grants[i] != grants[i - 1]), 32'd1);
    end

    // Reset while a read is waiting on memory
    grants.delete();
    grantCyc.delete();
    pushCmd(0, 1'b0, 32'h50, 32'h0, 4'h0, 0);
    n = 0;
    while (grants.size() == 0 && n < 20) begin
      step(1'b0);
      n++;
    end
    if (n >= 20) checkOutput("reset_grant_timeout", 32'(n), 32'd19);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    step(1'b0);
    step(1'b0);
    grants.delete();
    grantCyc.delete();
    pushCmd(0, 1'b0, 32'h60, 32'h0, 4'h0, 0);
    pushCmd(1, 1'b0, 32'h64, 32'h0, 4'h0, 0);
    runUntilQuiet(100);
    checkOutput("tie_count", 32'(grants.size()), 32'd2);
    if (grants.size() > 0) checkOutput("tie_after_reset", 32'(grants[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
